// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and parity helper.
// Used by uart_rx and intended for the transmitter rewrite as well.
package uart_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_CLKS_PER_BIT = 2604;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic even_parity_ok(input logic [UART_DATA_BITS-1:0] d, input logic p);
    return ~(^d ^ p);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for asynchronous pad inputs; resets to 1 so an idle-high
// line (UART rx, active-low buttons) reads as inactive out of reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, mid-bit sampling with a single-cycle valid strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  logic                      w_fall;
  logic                      w_half_done;
  logic                      w_bit_done;
  logic                      r_rx_prev;
  uart_state_e               r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
`ifdef UART_RX_PARITY_EN
  logic                      r_par;
`endif

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_rx),
    .o_q  (w_rx_s)
  );

  // Only a 1->0 transition starts a frame, so a line stuck low cannot retrigger.
  assign w_fall      = r_rx_prev & ~w_rx_s;
  assign w_half_done = (r_cnt == HALF_M1);
  assign w_bit_done  = (r_cnt == FULL_M1);
  assign o_busy      = (r_state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_rx_prev   <= 1'b1;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      o_rx_data   <= 8'h00;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_prev   <= w_rx_s;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_fall) begin
            r_state <= START;
          end
        end

        START: begin
          if (w_half_done) begin
            r_cnt <= '0;
            r_idx <= '0;
            // Line back high at mid start bit means it was a glitch.
            r_state <= w_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (w_bit_done) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx_s;
            if (r_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_par   <= w_rx_s;
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            if (!w_rx_s) begin
              o_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (!even_parity_ok(r_shift, r_par)) begin
              o_parity_err <= 1'b1;
`endif
            end else begin
              o_rx_data  <= r_shift;
              o_rx_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: good frames, back-to-back, glitch,
// framing error with stuck-low line, mid-frame reset, and parity when enabled.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor totals, only written by the monitor process.
  int tot_valid  = 0;
  int tot_ferr   = 0;
  int tot_perr   = 0;
  int width_errs = 0;
  int excl_errs  = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr  = 1'b0;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .o_frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(parity_err),
`endif
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) tot_valid = tot_valid + 1;
    if (frame_err) tot_ferr = tot_ferr + 1;
    if ((rx_valid && prev_valid) || (frame_err && prev_ferr)) width_errs = width_errs + 1;
    if (rx_valid && frame_err) excl_errs = excl_errs + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) tot_perr = tot_perr + 1;
    if (parity_err && (rx_valid || frame_err)) excl_errs = excl_errs + 1;
`endif
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par) begin end
`endif
    drive_bit(stop);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  int v0, f0, p0;

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  {24'd0, rx_data}, 32'h00);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_ferr",  {31'd0, frame_err}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single good frame
    v0 = tot_valid; f0 = tot_ferr;
    send_frame(8'hA5, even_par(8'hA5), 1'b1);
    check("a5_valid_cnt", tot_valid - v0, 32'd1);
    check("a5_data",      {24'd0, rx_data}, 32'hA5);
    check("a5_ferr_cnt",  tot_ferr - f0, 32'd0);
    check("a5_busy_after", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clk);

    // Back-to-back, no idle gap
    v0 = tot_valid;
    send_frame(8'h3C, even_par(8'h3C), 1'b1);
    check("b2b_first_cnt",  tot_valid - v0, 32'd1);
    check("b2b_first_data", {24'd0, rx_data}, 32'h3C);
    send_frame(8'hFF, even_par(8'hFF), 1'b1);
    check("b2b_total_cnt",  tot_valid - v0, 32'd2);
    check("b2b_second_data", {24'd0, rx_data}, 32'hFF);
    repeat (10) @(negedge clk);

    // 4-clock low glitch on idle line
    v0 = tot_valid; f0 = tot_ferr;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_seen", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy_after", {31'd0, busy}, 32'd0);
    check("glitch_no_valid", tot_valid - v0, 32'd0);
    check("glitch_no_ferr",  tot_ferr - f0, 32'd0);
    check("glitch_data",     {24'd0, rx_data}, 32'hFF);

    // Stop bit low, then line stuck low
    v0 = tot_valid; f0 = tot_ferr;
    send_frame(8'h55, even_par(8'h55), 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("ferr_cnt",        tot_ferr - f0, 32'd1);
    check("ferr_no_valid",   tot_valid - v0, 32'd0);
    check("ferr_data_kept",  {24'd0, rx_data}, 32'hFF);
    check("ferr_no_retrig",  {31'd0, busy}, 32'd0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_release_busy", {31'd0, busy}, 32'd0);
    check("ferr_release_cnt",  tot_ferr - f0, 32'd1);

    // Reset during data bit 4 of 8'h81
    v0 = tot_valid; f0 = tot_ferr;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i));
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    check("abort_busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    rx  = 1'b1;
    #2;
    check("abort_busy_rst", {31'd0, busy}, 32'd0);
    check("abort_data_rst", {24'd0, rx_data}, 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_valid", tot_valid - v0, 32'd0);
    check("abort_no_ferr",  tot_ferr - f0, 32'd0);
    send_frame(8'h42, even_par(8'h42), 1'b1);
    check("after_abort_cnt",  tot_valid - v0, 32'd1);
    check("after_abort_data", {24'd0, rx_data}, 32'h42);
    repeat (10) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // Even parity: 8'h07 has three ones, parity bit must be 1
    v0 = tot_valid; p0 = tot_perr;
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_good_valid", tot_valid - v0, 32'd1);
    check("par_good_perr",  tot_perr - p0, 32'd0);
    check("par_good_data",  {24'd0, rx_data}, 32'h07);
    repeat (10) @(negedge clk);
    v0 = tot_valid; p0 = tot_perr;
    send_frame(8'h07, 1'b0, 1'b1);
    check("par_bad_perr",  tot_perr - p0, 32'd1);
    check("par_bad_valid", tot_valid - v0, 32'd0);
    check("par_bad_data",  {24'd0, rx_data}, 32'h07);
    repeat (10) @(negedge clk);
`else
    p0 = tot_perr;
    check("no_parity_pulses", p0, 32'd0);
`endif

    check("pulse_width", width_errs, 32'd0);
    check("pulse_excl",  excl_errs, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
